// File: rtl/eth_txc_pkg.sv
// ============================================================================
// eth_txc_pkg : shared types and helpers for the RGMII/GMII TX clock-enable
//               generator (mode encoding, per-mode timing, width check).
// Revision    : 1.0
// ============================================================================
`default_nettype none

package eth_txc_pkg;

  typedef enum logic [1:0] {
    MODE_1G   = 2'd0,
    MODE_100M = 2'd1,
    MODE_10M  = 2'd2
  } mode_t;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] edge1;
    logic [31:0] edge2;
  } mode_timing_t;

  // 1G has a period of one cycle; its edge values are never consulted.
  function automatic mode_timing_t mode_timing(
    input mode_t m,
    input int    div_100,
    input int    div_10,
    input int    edge1_100,
    input int    edge2_100,
    input int    edge1_10,
    input int    edge2_10
  );
    mode_timing_t t;
    t.period = 32'd1;
    t.edge1  = '1;
    t.edge2  = '1;
    case (m)
      MODE_100M: begin
        t.period = 32'(div_100);
        t.edge1  = 32'(edge1_100);
        t.edge2  = 32'(edge2_100);
      end
      MODE_10M: begin
        t.period = 32'(div_10);
        t.edge1  = 32'(edge1_10);
        t.edge2  = 32'(edge2_10);
      end
      default: ;
    endcase
    return t;
  endfunction

  function automatic mode_t decode_mode(
    input logic speed_10_100,
    input logic speed_100
  );
    mode_t m;
    if (!speed_10_100)  m = MODE_1G;
    else if (speed_100) m = MODE_100M;
    else                m = MODE_10M;
    return m;
  endfunction

  function automatic bit cnt_w_fits(input int cnt_w, input int div_10);
    return (longint'(1) << cnt_w) >= longint'(div_10);
  endfunction

endpackage : eth_txc_pkg

`default_nettype wire

// File: rtl/eth_speed_sync.sv
// ============================================================================
// eth_speed_sync : two-flop synchroniser for the speed select inputs.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module eth_speed_sync #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule : eth_speed_sync

`default_nettype wire

// File: rtl/eth_txc_en_gen_p.sv
// ============================================================================
// eth_txc_en_gen_p : period-aligned GMII / client / RGMII-ODDR enables for
//                    1000/100/10 Mbps from one 125 MHz clock.
//                    Optional macro ETH_TXC_SPEED_SYNC_EN adds input syncs.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module eth_txc_en_gen_p
  import eth_txc_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int DIV_100    = 5,
  parameter int DIV_10     = 50,
  parameter int EDGE1_100  = 1,
  parameter int EDGE2_100  = 2,
  parameter int EDGE1_10   = 23,
  parameter int EDGE2_10   = 24,
  parameter int CLIENT_DIV = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       speed_10_100,
  input  logic       speed_100,
  output logic       gmii_txc_en,
  output logic       client_txc_en,
  output logic       rgmii_txc_en,
  output logic       rgmii_txc_en_shift,
  output logic [1:0] mode,
  output logic       mode_switch
);

  localparam int CLI_W = (CLIENT_DIV > 1) ? $clog2(CLIENT_DIV) : 1;
  localparam logic [CLI_W-1:0] CLI_LAST = CLI_W'(CLIENT_DIV - 1);

  if (!cnt_w_fits(CNT_W, DIV_10) || DIV_100 < 3 || DIV_10 < 3 || CLIENT_DIV < 1)
  begin : g_param_check
    $error("eth_txc_en_gen_p: illegal parameter combination");
  end

  logic [1:0]       speed_raw;
  logic [1:0]       speed_dec;
  mode_t            mode_req;
  mode_t            cur_mode;
  mode_timing_t     timing;
  logic [CNT_W-1:0] counter;
  logic [31:0]      cnt_ext;
  logic [CLI_W-1:0] client_cnt;
  logic             tick;
  logic             en_int;
  logic             shift_int;

  assign speed_raw = {speed_10_100, speed_100};

`ifdef ETH_TXC_SPEED_SYNC_EN
  eth_speed_sync #(
    .WIDTH    (2)
  ) u_speed_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (speed_raw),
    .sync_out (speed_dec)
  );
`else
  assign speed_dec = speed_raw;
`endif

  assign mode_req = decode_mode(speed_dec[1], speed_dec[0]);
  assign timing   = mode_timing(cur_mode, DIV_100, DIV_10,
                                EDGE1_100, EDGE2_100, EDGE1_10, EDGE2_10);
  assign cnt_ext  = 32'(counter);

  // The 1G period is one cycle, so the counter sits at 0 and tick stays high.
  assign tick = (cnt_ext == timing.period - 32'd1);
  assign mode = cur_mode;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_mode    <= MODE_1G;
      counter     <= '0;
      client_cnt  <= '0;
      mode_switch <= 1'b0;
    end else if (tick && (mode_req != cur_mode)) begin
      cur_mode    <= mode_req;
      counter     <= '0;
      client_cnt  <= '0;
      mode_switch <= 1'b1;
    end else begin
      mode_switch <= 1'b0;
      if (tick) begin
        counter    <= '0;
        client_cnt <= (client_cnt == CLI_LAST) ? '0 : client_cnt + CLI_W'(1);
      end else begin
        counter    <= counter + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gmii_txc_en        <= 1'b0;
      client_txc_en      <= 1'b0;
      en_int             <= 1'b0;
      shift_int          <= 1'b0;
      rgmii_txc_en       <= 1'b0;
      rgmii_txc_en_shift <= 1'b0;
    end else begin
      gmii_txc_en        <= tick;
      client_txc_en      <= (cur_mode == MODE_1G) || (tick && (client_cnt == '0));
      rgmii_txc_en       <= en_int;
      rgmii_txc_en_shift <= shift_int;
      // Edge values at or beyond the period never match, so that enable stays high.
      if (cur_mode == MODE_1G) begin
        en_int    <= 1'b0;
        shift_int <= 1'b1;
      end else if (tick) begin
        en_int    <= 1'b1;
        shift_int <= 1'b1;
      end else if (cnt_ext == timing.edge1) begin
        en_int    <= 1'b0;
      end else if (cnt_ext == timing.edge2) begin
        shift_int <= 1'b0;
      end
    end
  end

endmodule : eth_txc_en_gen_p

`default_nettype wire

// File: tb/tb_eth_txc_en_gen_p.sv
// ============================================================================
// tb_eth_txc_en_gen_p : self-checking bench for eth_txc_en_gen_p.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_eth_txc_en_gen_p;

  localparam int DIV_100    = 5;
  localparam int DIV_10     = 50;
  localparam int EDGE1_100  = 1;
  localparam int EDGE2_100  = 2;
  localparam int EDGE1_10   = 23;
  localparam int EDGE2_10   = 24;
  localparam int CLIENT_DIV = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       speed_10_100 = 1'b0;
  logic       speed_100 = 1'b0;
  logic       gmii_txc_en;
  logic       client_txc_en;
  logic       rgmii_txc_en;
  logic       rgmii_txc_en_shift;
  logic [1:0] mode;
  logic       mode_switch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eth_txc_en_gen_p #(
    .CNT_W      (8),
    .DIV_100    (DIV_100),
    .DIV_10     (DIV_10),
    .EDGE1_100  (EDGE1_100),
    .EDGE2_100  (EDGE2_100),
    .EDGE1_10   (EDGE1_10),
    .EDGE2_10   (EDGE2_10),
    .CLIENT_DIV (CLIENT_DIV)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .speed_10_100       (speed_10_100),
    .speed_100          (speed_100),
    .gmii_txc_en        (gmii_txc_en),
    .client_txc_en      (client_txc_en),
    .rgmii_txc_en       (rgmii_txc_en),
    .rgmii_txc_en_shift (rgmii_txc_en_shift),
    .mode               (mode),
    .mode_switch        (mode_switch)
  );

  wire [6:0] dut_vec = {mode, mode_switch, rgmii_txc_en_shift, rgmii_txc_en,
                        client_txc_en, gmii_txc_en};

  // Reference model: position within the current period plus the spec's enable rules.
  int        m_mode, m_pos, m_cli;
  bit        m_en, m_sh;
  bit [1:0]  m_s1, m_s2;
  logic [6:0] exp_vec;

  bit [1:0] spd_m;
  int       req_m, per_m, e1_m, e2_m, n_mode, n_pos, n_cli;
  bit       tck_m, sw_m, n_en, n_sh, cli_m;
  logic [6:0] n_vec;

  always_comb begin
`ifdef ETH_TXC_SPEED_SYNC_EN
    spd_m = m_s2;
`else
    spd_m = {speed_10_100, speed_100};
`endif
    req_m = !spd_m[1] ? 0 : (spd_m[0] ? 1 : 2);
    per_m = (m_mode == 0) ? 1 : ((m_mode == 1) ? DIV_100 : DIV_10);
    e1_m  = (m_mode == 1) ? EDGE1_100 : EDGE1_10;
    e2_m  = (m_mode == 1) ? EDGE2_100 : EDGE2_10;
    tck_m = (m_pos == per_m - 1);
    sw_m  = tck_m && (req_m != m_mode);
    cli_m = (m_mode == 0) || (tck_m && m_cli == 0);
    n_en  = m_en;
    n_sh  = m_sh;
    if (m_mode == 0) begin
      n_en = 1'b0;
      n_sh = 1'b1;
    end else if (tck_m) begin
      n_en = 1'b1;
      n_sh = 1'b1;
    end else if (m_pos == e1_m) begin
      n_en = 1'b0;
    end else if (m_pos == e2_m) begin
      n_sh = 1'b0;
    end
    n_mode = sw_m ? req_m : m_mode;
    n_pos  = tck_m ? 0 : m_pos + 1;
    n_cli  = sw_m ? 0 : (tck_m ? (m_cli + 1) % CLIENT_DIV : m_cli);
    n_vec  = {2'(n_mode), sw_m, m_sh, m_en, cli_m, tck_m};
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode  <= 0;
      m_pos   <= 0;
      m_cli   <= 0;
      m_en    <= 1'b0;
      m_sh    <= 1'b0;
      m_s1    <= 2'b00;
      m_s2    <= 2'b00;
      exp_vec <= '0;
    end else begin
      m_s1    <= {speed_10_100, speed_100};
      m_s2    <= m_s1;
      m_mode  <= n_mode;
      m_pos   <= n_pos;
      m_cli   <= n_cli;
      m_en    <= n_en;
      m_sh    <= n_sh;
      exp_vec <= n_vec;
    end
  end

  task automatic wait_gmii(input string name);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL %s_model: got %b want %b", name, dut_vec, exp_vec);
      end
      found = (gmii_txc_en === 1'b1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_align: gmii_txc_en pulse not seen within 200 cycles", name);
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    speed_10_100 = 1'b0;
    speed_100    = 1'($urandom_range(0, 1));
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec !== 7'd0) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", dut_vec, 7'd0);
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      speed_100 = 1'($urandom_range(0, 1));
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_1g_model: cycle %0d got %b want %b", i, dut_vec, exp_vec);
      end
      checks++;
      if ({gmii_txc_en, client_txc_en, rgmii_txc_en, mode, mode_switch} !== 6'b110000 ||
          (i >= 2 && rgmii_txc_en_shift !== 1'b1)) begin
        errors++;
        $display("FAIL reset_1g_pattern: cycle %0d got %b want g=1 c=1 r=0 s=1 mode=0", i, dut_vec);
      end
    end
  endtask

  task automatic test_100m();
    int sw_cnt = 0;
    int n_g = 0, n_e = 0, n_s = 0, n_c = 0, last_c = -1;
    bit g[50], e[50], s[50];
    speed_10_100 = 1'b1;
    speed_100    = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL 100m_switch_model: got %b want %b", dut_vec, exp_vec);
      end
      if (mode_switch === 1'b1) sw_cnt++;
    end
    checks++;
    if (sw_cnt != 1 || mode !== 2'd1) begin
      errors++;
      $display("FAIL 100m_switch: pulses %0d mode %0d want 1 pulse mode 1", sw_cnt, mode);
    end
    wait_gmii("100m");
    for (int k = 0; k < 50; k++) begin
      if (k > 0) begin
        @(negedge clk);
        checks++;
        if (dut_vec !== exp_vec) begin
          errors++;
          $display("FAIL 100m_model: got %b want %b", dut_vec, exp_vec);
        end
      end
      g[k] = gmii_txc_en; e[k] = rgmii_txc_en; s[k] = rgmii_txc_en_shift;
      n_g += int'(gmii_txc_en); n_e += int'(rgmii_txc_en); n_s += int'(rgmii_txc_en_shift);
      if (client_txc_en) begin
        checks++;
        if (last_c >= 0 && k - last_c != DIV_100 * CLIENT_DIV) begin
          errors++;
          $display("FAIL 100m_client_gap: got %0d want %0d", k - last_c, DIV_100 * CLIENT_DIV);
        end
        last_c = k;
        n_c++;
      end
      if (k >= 3) begin
        checks++;
        if (e[k] != (g[k-1] | g[k-2]) || s[k] != (g[k-1] | g[k-2] | g[k-3])) begin
          errors++;
          $display("FAIL 100m_phase: k %0d got en %0d sh %0d want %0d %0d", k, e[k], s[k],
                   g[k-1] | g[k-2], g[k-1] | g[k-2] | g[k-3]);
        end
      end
    end
    checks++;
    if (n_g != 10 || n_e != 20 || n_s != 30 || n_c != 5) begin
      errors++;
      $display("FAIL 100m_duty: got g%0d e%0d s%0d c%0d want g10 e20 s30 c5", n_g, n_e, n_s, n_c);
    end
  endtask

  task automatic test_10m();
    int n_g = 0, n_e = 0, n_s = 0, n_c = 0;
    speed_10_100 = 1'b1;
    speed_100    = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL 10m_switch_model: got %b want %b", dut_vec, exp_vec);
      end
    end
    wait_gmii("10m");
    for (int k = 0; k < 200; k++) begin
      if (k > 0) begin
        @(negedge clk);
        checks++;
        if (dut_vec !== exp_vec) begin
          errors++;
          $display("FAIL 10m_model: got %b want %b", dut_vec, exp_vec);
        end
      end
      n_g += int'(gmii_txc_en); n_e += int'(rgmii_txc_en);
      n_s += int'(rgmii_txc_en_shift); n_c += int'(client_txc_en);
    end
    checks++;
    if (n_g != 4 || n_e != 96 || n_s != 100 || n_c != 2 || mode !== 2'd2) begin
      errors++;
      $display("FAIL 10m_duty: got g%0d e%0d s%0d c%0d mode %0d want g4 e96 s100 c2 mode 2",
               n_g, n_e, n_s, n_c, mode);
    end
  endtask

  task automatic test_mid_switch();
    int k_sw = -1, k_g = -1;
    wait_gmii("mid");
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL mid_model: got %b want %b", dut_vec, exp_vec);
      end
    end
    speed_100 = 1'b1;
    for (int k = 1; k <= 60 && k_sw < 0; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL mid_model: got %b want %b", dut_vec, exp_vec);
      end
      if (mode_switch === 1'b1) k_sw = k;
    end
    checks++;
    if (k_sw != DIV_10 - 10 || gmii_txc_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_switch_point: got cycle %0d gmii %0d want cycle %0d gmii 1",
               k_sw, gmii_txc_en, DIV_10 - 10);
    end
    for (int k = 1; k <= 20 && k_g < 0; k++) begin
      @(negedge clk);
      if (gmii_txc_en === 1'b1) k_g = k;
    end
    checks++;
    if (k_g != DIV_100) begin
      errors++;
      $display("FAIL mid_first_100m_pulse: got %0d cycles want %0d", k_g, DIV_100);
    end
  endtask

  task automatic test_glitch();
    int n_g = 0, n_sw = 0;
    wait_gmii("glitch");
    speed_100 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL glitch_model: got %b want %b", dut_vec, exp_vec);
      end
    end
    speed_100 = 1'b1;
    repeat (30) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL glitch_model: got %b want %b", dut_vec, exp_vec);
      end
      n_g  += int'(gmii_txc_en);
      n_sw += int'(mode_switch);
    end
    checks++;
    if (n_sw != 0 || n_g != 6 || mode !== 2'd1) begin
      errors++;
      $display("FAIL glitch_cancel: got switches %0d pulses %0d mode %0d want 0 6 1", n_sw, n_g, mode);
    end
  endtask

  task automatic test_async_reset();
    wait_gmii("areset");
    repeat (2) @(negedge clk);
    #3;
    reset_n      = 1'b0;
    speed_10_100 = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 7'd0) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b want %b", dut_vec, 7'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec || gmii_txc_en !== 1'b1 || mode !== 2'd0) begin
        errors++;
        $display("FAIL async_reset_restart: cycle %0d got %b want %b", i, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 40; seg++) begin
      speed_10_100 = 1'($urandom_range(0, 1));
      speed_100    = 1'($urandom_range(0, 1));
      hold         = int'($urandom_range(1, 150));
      repeat (hold) begin
        @(negedge clk);
        checks++;
        if (dut_vec !== exp_vec) begin
          errors++;
          $display("FAIL random_model: seg %0d got %b want %b", seg, dut_vec, exp_vec);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_100m();
    test_10m();
    test_mid_switch();
    test_glitch();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_eth_txc_en_gen_p

`default_nettype wire

// File: doc/eth_txc_en_gen_p.md
Name: eth_txc_en_gen_p

Overview:
Parametrised successor of the RGMII/GMII transmit clock-enable generator. From one 125 MHz clock it produces period-aligned enables for GMII data, the MAC client, and the RGMII TXC ODDR pair at 1000/100/10 Mbps. Divide ratios, ODDR edge positions and client ratio are parameters. Speed changes apply only at a period boundary, so no enable is ever truncated. Sits between the MAC TX path and the rgmii_interface ODDR stage.

Parameters:
CNT_W, 8, counter width; must satisfy 2**CNT_W >= DIV_10
DIV_100, 5, clk cycles per period at 100 Mbps (>=3)
DIV_10, 50, clk cycles per period at 10 Mbps (>=3)
EDGE1_100, 1, counter value clearing rgmii_txc_en_int at 100 Mbps
EDGE2_100, 2, counter value clearing rgmii_txc_en_shift_int at 100 Mbps
EDGE1_10, 23, as EDGE1_100 for 10 Mbps
EDGE2_10, 24, as EDGE2_100 for 10 Mbps
CLIENT_DIV, 2, periods per client enable in 10/100 mode (>=1)

Ports:
clk  in  1  125 MHz gtx clock
reset_n  in  1  asynchronous active-low reset
speed_10_100  in  1  1 = 10/100 Mbps, 0 = 1 Gbps
speed_100  in  1  1 = 100 Mbps when speed_10_100 = 1
gmii_txc_en  out  1  one-cycle pulse per period
client_txc_en  out  1  one-cycle pulse every CLIENT_DIV periods (every cycle at 1G)
rgmii_txc_en  out  1  ODDR rising-phase enable
rgmii_txc_en_shift  out  1  ODDR shifted-phase enable
mode  out  2  active mode: 0 = 1G, 1 = 100M, 2 = 10M
mode_switch  out  1  one-cycle pulse when mode changes

Behaviour:
- Reset (async assert, sync release): counter = 0, mode = 0, client count = 0, all outputs 0.
- mode_req: 0 if speed_10_100 = 0 (speed_100 ignored); 1 if both are 1; 2 if speed_10_100 = 1 and speed_100 = 0. Encoding 3 is never produced.
- Period P = 1 / DIV_100 / DIV_10 for mode 0/1/2.
- Counter runs 0..P-1 and wraps. tick = (counter == P-1); tick is constant 1 in 1G.
- Mode switch: a switch is pending when mode_req != mode. It commits on a tick cycle: mode <= mode_req, counter <= 0, client count <= 0, mode_switch = 1 on the next cycle.
- A request that reverts before the tick cancels with no switch. Mid-period changes never shorten a period.
- gmii_txc_en <= tick. Latency is 1 cycle.
- client: client count increments on tick and wraps at CLIENT_DIV-1. client_txc_en <= tick and count == 0. In 1G, client_txc_en <= 1 every cycle.
- rgmii internal, mode 1/2:
  - On tick: en_int = 1 and shift_int = 1.
  - Else if counter == EDGE1: en_int = 0.
  - Else if counter == EDGE2: shift_int = 0.
  - Otherwise both hold.
- rgmii internal, 1G: en_int = 0 and shift_int = 1.
- rgmii_txc_en and rgmii_txc_en_shift are en_int and shift_int delayed one more register. They lag gmii_txc_en by exactly 1 cycle.
- At 100 Mbps, defaults: gmii_txc_en is high 1 of 5 cycles; rgmii_txc_en is high 2 of 5; rgmii_txc_en_shift is high 3 of 5.
- EDGE values >= P are never matched; that enable then stays high.

Optional Feature:
ETH_TXC_SPEED_SYNC_EN
- Defined: speed_10_100 and speed_100 each pass through a 2-flop synchroniser (reset 0) before decode. A speed change reaches mode_req 2 cycles later.
- Undefined: inputs are clk-synchronous and decoded directly. Latency to mode_req is 0.

Decomposition:
- Package eth_txc_pkg holds:
  - the mode typedef (2-bit enum MODE_1G, MODE_100M, MODE_10M);
  - a constant function returning period/EDGE1/EDGE2 per mode;
  - a CNT_W check function.
- One sub-module, eth_speed_sync: the 2-flop synchroniser, instantiated only under ETH_TXC_SPEED_SYNC_EN.
- Counter, mode commit and enable generation stay in the top level.

Test Plan:
- Reset with speed = 1G (0,x), release: gmii_txc_en = 1 every cycle from cycle 1; client_txc_en = 1; rgmii_txc_en = 0; rgmii_txc_en_shift = 1; mode = 0.
- Set 100M (1,1): mode_switch pulses once and mode = 1. Then gmii_txc_en repeats 10000 (period 5), rgmii_txc_en repeats 11000 offset 1 cycle, rgmii_txc_en_shift repeats 11100, client_txc_en pulses every 10 cycles.
- 10M (1,0): gmii_txc_en period 50, rgmii_txc_en high 24 cycles, rgmii_txc_en_shift high 25 cycles, client_txc_en period 100.
- In 10M at counter = 10, switch to 100M: no switch until counter reaches 49; first 100M gmii_txc_en pulse lands exactly 5 cycles after the last 10M pulse.
- In 100M, toggle speed_100 low for 2 cycles mid-period: no mode_switch, no pattern disturbance.
- Assert reset_n low mid-period asynchronously: all outputs drop to 0 in the same cycle without waiting for clk; after release, the sequence restarts from counter 0 in mode 0.
